// File: rtl/led_sequencer_if.sv
// APB bus bundle between the CPU segment and the LED sequencer.
// Latency: none, wires only.
// Backpressure: none; the slave ties PREADY high.
// Signals: PSEL/PENABLE/PWRITE/PADDR/PWDATA from the master; PRDATA/PREADY/PSLVERR from the slave.
interface led_sequencer_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/led_sequencer.sv
// Steps the 8-bit LED bank through a software-loaded pattern table (APB slave).
// Latency: writes commit on the access-phase edge; LED/STATUS change one edge after the cause.
// Backpressure: none; PREADY tied 1, unmapped accesses flag PSLVERR.
// Ports: PCLK, PRESETN (async active-low), apb (slave modport), LED (registered drive).
module led_sequencer #(
    parameter int CNT_W = 24
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    led_sequencer_if.slave     apb,
    output logic [7:0]         LED
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} state_t;

    // Configuration registers
    logic             r_en;
    logic             r_loop;
    logic [2:0]       r_last;
    logic [CNT_W-1:0] r_period;
    logic [7:0]       r_manual;
    logic [7:0]       r_pat [8];

    // Sequencer state
    state_t           r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [7:0]       r_led;

    logic [5:0]       w_word;
    logic             w_access;
    logic             w_wr;
    logic             w_mapped;
    logic             w_is_pat;
    logic             w_wr_ctrl;
    logic             w_wr_period;
    logic             w_wr_manual;
    logic             w_wr_pat;
    logic [CNT_W-1:0] w_term;
    logic             w_at_term;
    logic [2:0]       w_idx_nxt;
    logic             w_unused;

    assign w_word      = apb.PADDR[7:2];
    assign w_access    = apb.PSEL & apb.PENABLE;
    assign w_wr        = w_access & apb.PWRITE;
    // Pattern table occupies words 8..15 (bytes 0x20..0x3C).
    assign w_is_pat    = (w_word[5:3] == 3'b001);
    assign w_mapped    = (w_word <= 6'd3) | w_is_pat;
    assign w_wr_ctrl   = w_wr & (w_word == 6'd0);
    assign w_wr_period = w_wr & (w_word == 6'd1);
    assign w_wr_manual = w_wr & (w_word == 6'd3);
    assign w_wr_pat    = w_wr & w_is_pat;

    // A period of 0 is treated as 1, so the terminal count is 0 in both cases.
    assign w_term      = (r_period == '0) ? '0 : r_period - CNT_W'(1);
    assign w_at_term   = (r_cnt == w_term);
    assign w_idx_nxt   = r_idx + 3'd1;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = w_access & ~w_mapped;
    assign LED         = r_led;

    // Upper data bits beyond the widest register and the byte-offset bits are don't-care.
    assign w_unused    = &{1'b0, apb.PWDATA, apb.PADDR};

    always_comb begin
        apb.PRDATA = 32'd0;
        if (w_is_pat) begin
            apb.PRDATA = {24'd0, r_pat[w_word[2:0]]};
        end else begin
            case (w_word)
                6'd0:    apb.PRDATA = {27'd0, r_last, r_loop, r_en};
                6'd1:    apb.PRDATA = 32'(r_period);
                6'd2:    apb.PRDATA = {22'd0, r_done, (r_state == ST_RUN), 5'd0, r_idx};
                6'd3:    apb.PRDATA = {24'd0, r_manual};
                default: apb.PRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_en     <= 1'b0;
            r_loop   <= 1'b0;
            r_last   <= 3'd0;
            r_period <= '0;
            r_manual <= 8'h01;
            for (int i = 0; i < 8; i++) begin
                r_pat[i] <= 8'h00;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= apb.PWDATA[0];
                r_loop <= apb.PWDATA[1];
                r_last <= apb.PWDATA[4:2];
            end
            if (w_wr_period) r_period <= apb.PWDATA[CNT_W-1:0];
            if (w_wr_manual) r_manual <= apb.PWDATA[7:0];
            if (w_wr_pat)    r_pat[w_word[2:0]] <= apb.PWDATA[7:0];
        end
    end

    // A CTRL write overrides whatever the sequencer would otherwise do on that edge.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_led   <= 8'h01;
        end else if (w_wr_ctrl) begin
            r_done <= 1'b0;
            if (apb.PWDATA[0]) begin
                r_state <= ST_RUN;
                r_idx   <= 3'd0;
                r_cnt   <= '0;
                r_led   <= r_pat[0];
            end else begin
                r_state <= ST_IDLE;
                r_led   <= r_manual;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Show a MANUAL write on the same edge it lands.
                    r_led <= w_wr_manual ? apb.PWDATA[7:0] : r_manual;
                end
                ST_RUN: begin
                    if (w_at_term) begin
                        r_cnt <= '0;
                        if (r_idx != r_last) begin
                            r_idx <= w_idx_nxt;
                            r_led <= r_pat[w_idx_nxt];
                        end else if (r_loop) begin
                            r_idx <= 3'd0;
                            r_led <= r_pat[0];
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // FINISH: LED and idx hold until the next CTRL write.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a cycle-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_sequencer;

    logic PCLK;
    logic PRESETN;
    logic [7:0] LED;
    led_sequencer_if apb();

    led_sequencer #(.CNT_W(24)) dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .apb     (apb.slave),
        .LED     (LED)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int S_IDLE = 0, S_RUN = 1, S_FIN = 2;
    logic        m_en, m_loop;
    logic [2:0]  m_last, m_idx;
    logic [23:0] m_period;
    logic [7:0]  m_manual, m_led;
    logic [7:0]  m_pat [8];
    logic        m_done;
    int          m_st;
    int          m_k;    // edges elapsed since the start edge

    function automatic bit is_mapped(input logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        return (w <= 3) || (w >= 8 && w <= 15);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int w;
        w = int'(a[7:2]);
        if (w >= 8 && w <= 15) return {24'd0, m_pat[w-8]};
        case (w)
            0: return {27'd0, m_last, m_loop, m_en};
            1: return {8'd0, m_period};
            2: return {22'd0, m_done, (m_st == S_RUN), 5'd0, m_idx};
            3: return {24'd0, m_manual};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            m_en = 0; m_loop = 0; m_last = 0; m_period = 0; m_manual = 8'h01;
            for (int i = 0; i < 8; i++) m_pat[i] = 8'h00;
            m_st = S_IDLE; m_idx = 0; m_k = 0; m_done = 0; m_led = 8'h01;
        end else begin
            bit wr;
            int w, p, step;
            wr = apb.PSEL && apb.PENABLE && apb.PWRITE;
            w  = int'(apb.PADDR[7:2]);
            if (wr && w == 0) begin
                m_en = apb.PWDATA[0]; m_loop = apb.PWDATA[1]; m_last = apb.PWDATA[4:2];
                m_done = 0;
                if (m_en) begin
                    m_st = S_RUN; m_k = 0; m_idx = 0; m_led = m_pat[0];
                end else begin
                    m_st = S_IDLE; m_led = m_manual;
                end
            end else if (m_st == S_IDLE) begin
                m_led = (wr && w == 3) ? apb.PWDATA[7:0] : m_manual;
            end else if (m_st == S_RUN) begin
                m_k++;
                p = (m_period == 0) ? 1 : int'(m_period);
                if (m_k % p == 0) begin
                    step = m_k / p;
                    if (m_loop) begin
                        m_idx = 3'(step % (int'(m_last) + 1));
                        m_led = m_pat[m_idx];
                    end else if (step > int'(m_last)) begin
                        m_st = S_FIN; m_done = 1;
                    end else begin
                        m_idx = 3'(step);
                        m_led = m_pat[m_idx];
                    end
                end
            end
            if (wr) begin
                if (w == 1) m_period = apb.PWDATA[23:0];
                if (w == 3) m_manual = apb.PWDATA[7:0];
                if (w >= 8 && w <= 15) m_pat[w-8] = apb.PWDATA[7:0];
            end
        end
    end

    always @(negedge PCLK) begin
        if (cmp_on) begin
            chk("led_vs_model", {24'd0, LED}, {24'd0, m_led});
            chk("prdata_vs_model", apb.PRDATA, m_read(apb.PADDR));
            chk("pslverr_vs_model", {31'd0, apb.PSLVERR},
                {31'd0, apb.PSEL && apb.PENABLE && !is_mapped(apb.PADDR)});
            chk("pready", {31'd0, apb.PREADY}, 32'd1);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = a; apb.PWDATA = d;
        @(posedge PCLK); #1;
        apb.PENABLE = 1;
        #2 err = apb.PSLVERR;
        @(posedge PCLK); #1;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = a;
        @(posedge PCLK); #1;
        apb.PENABLE = 1;
        #2 begin d = apb.PRDATA; err = apb.PSLVERR; end
        @(posedge PCLK); #1;
        apb.PSEL = 0; apb.PENABLE = 0;
    endtask

    logic [7:0] exp_os [12] = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02,
                                8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};

    initial begin
        logic [31:0] d;
        logic e;
        PRESETN = 0;
        apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = 8'h0C; apb.PWDATA = 0;
        repeat (2) @(posedge PCLK);
        #1;
        chk("reset_led", {24'd0, LED}, 32'h01);
        chk("reset_manual_rd", apb.PRDATA, 32'h01);
        chk("reset_pready", {31'd0, apb.PREADY}, 32'd1);
        apb.PADDR = 8'h08;
        #1 chk("reset_status_rd", apb.PRDATA, 32'h0);
        PRESETN = 1;
        cmp_on = 1;

        // Manual display in IDLE
        apb_write(8'h0C, 32'h5C, e);
        chk("manual_led", {24'd0, LED}, 32'h5C);
        apb_read(8'h0C, d, e);
        chk("manual_rd", d, 32'h5C);

        // One-shot, three patterns, period 3
        apb_write(8'h20, 32'h01, e);
        apb_write(8'h24, 32'h02, e);
        apb_write(8'h28, 32'h04, e);
        apb_write(8'h04, 32'd3, e);
        apb_write(8'h00, 32'h09, e);
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            chk($sformatf("oneshot_led[%0d]", i), {24'd0, LED}, {24'd0, exp_os[i]});
        end
        apb_read(8'h08, d, e);
        chk("oneshot_status", d, 32'h202);
        apb_read(8'h00, d, e);
        chk("oneshot_ctrl_rd", d, 32'h09);

        // Loop with period 0
        apb_write(8'h20, 32'hF0, e);
        apb_write(8'h24, 32'h0F, e);
        apb_write(8'h04, 32'd0, e);
        apb_write(8'h00, 32'h07, e);
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            chk($sformatf("loop_led[%0d]", i), {24'd0, LED}, (i % 2 == 0) ? 32'hF0 : 32'h0F);
        end
        apb_read(8'h08, d, e);
        chk("loop_busy_notdone", d & 32'h300, 32'h100);

        // Abort and restart
        apb_write(8'h00, 32'h00, e);
        chk("abort_led", {24'd0, LED}, 32'h5C);
        apb_read(8'h08, d, e);
        chk("abort_status", d & 32'h300, 32'h0);
        apb_write(8'h04, 32'd100, e);
        apb_write(8'h00, 32'h07, e);
        chk("restart_led", {24'd0, LED}, 32'hF0);
        apb_read(8'h08, d, e);
        chk("restart_status", d, 32'h100);

        // Error responses
        apb_write(8'h10, 32'hFFFF_FFFF, e);
        chk("wr_unmapped_err", {31'd0, e}, 32'd1);
        apb_read(8'h10, d, e);
        chk("rd_unmapped_err", {31'd0, e}, 32'd1);
        chk("rd_unmapped_dat", d, 32'h0);
        apb_write(8'h08, 32'hFFFF_FFFF, e);
        chk("wr_status_err", {31'd0, e}, 32'd0);
        apb_read(8'h08, d, e);
        chk("status_after_wr", d & 32'h300, 32'h100);
        apb_read(8'h00, d, e);
        chk("ctrl_unchanged", d, 32'h07);
        apb_read(8'h04, d, e);
        chk("period_unchanged", d, 32'd100);
        apb_read(8'h0C, d, e);
        chk("manual_unchanged", d, 32'h5C);

        // Asynchronous reset in the middle of a run
        apb_write(8'h20, 32'hAA, e);
        apb_write(8'h00, 32'h01, e);
        chk("prereset_led", {24'd0, LED}, 32'hAA);
        @(posedge PCLK); #3;
        PRESETN = 0;
        #1 chk("async_reset_led", {24'd0, LED}, 32'h01);
        apb.PADDR = 8'h08;
        #1 chk("async_reset_status", apb.PRDATA, 32'h0);
        @(posedge PCLK); #1;
        PRESETN = 1;
        apb_read(8'h0C, d, e);
        chk("post_reset_manual", d, 32'h01);
        apb_read(8'h20, d, e);
        chk("post_reset_pat0", d, 32'h0);

        repeat (2) @(posedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
